// File: rtl/nn_layer_tm.sv
// Time-multiplexed fully connected layer: buffers one input vector, then sweeps
// NUM_PE MAC lanes over the neurons pass by pass, applying bias, saturation and optional ReLU.
module nn_layer_tm #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 128,
  parameter int NUM_PE      = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACT_MODE    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [31:0]                      w_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0]     w_data,
  output logic [31:0]                      b_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0]     b_data,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int NUM_PASSES = (NUM_NEURONS + NUM_PE - 1) / NUM_PE;
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CNT_W      = $clog2(NUM_INPUTS + 1);
  localparam int P_W        = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int ACC_W      = 2 * DATA_WIDTH + $clog2(NUM_INPUTS);
  localparam int SUM_W      = ((ACC_W > DATA_WIDTH + FRAC_BITS) ? ACC_W : DATA_WIDTH + FRAC_BITS) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, MAC, FINISH, OUT} state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [P_W-1:0]                   p_q, p_d;
  logic [31:0]                      waddr_q, waddr_d;
  logic                             ovalid_q, ovalid_d;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] out_q, out_d;
  logic signed [ACC_W-1:0]          acc_q [NUM_PE];
  logic signed [ACC_W-1:0]          acc_d [NUM_PE];
  logic [DATA_WIDTH-1:0]            vec_q [NUM_INPUTS];
  logic                             vec_we;

  logic [IDX_W-1:0]                 rd_idx;
  logic signed [2*DATA_WIDTH-1:0]   prod  [NUM_PE];
  logic signed [SUM_W-1:0]          sum_w [NUM_PE];
  logic signed [SUM_W-1:0]          shr_w [NUM_PE];
  logic [DATA_WIDTH-1:0]            res   [NUM_PE];

  // Weight data arrives one cycle after its address, so MAC cycle k uses element k-1.
  assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));

  always_comb begin
    for (int unsigned j = 0; j < NUM_PE; j++) begin
      prod[j] = $signed(vec_q[rd_idx]) * $signed(w_data[j*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_PE; j++) begin
      sum_w[j] = SUM_W'(acc_q[j])
               + (SUM_W'($signed(b_data[j*DATA_WIDTH +: DATA_WIDTH])) <<< FRAC_BITS);
      shr_w[j] = sum_w[j] >>> FRAC_BITS;
      res[j]   = shr_w[j][DATA_WIDTH-1:0];
      if (shr_w[j] > SAT_MAX) begin
        res[j] = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shr_w[j] < SAT_MIN) begin
        res[j] = SAT_MIN[DATA_WIDTH-1:0];
      end
      if (ACT_MODE == 1 && res[j][DATA_WIDTH-1]) begin
        res[j] = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    waddr_d  = waddr_q;
    ovalid_d = ovalid_q;
    out_d    = out_q;
    acc_d    = acc_q;
    vec_we   = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          vec_we = 1'b1;
          if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
            idx_d   = '0;
            cnt_d   = '0;
            p_d     = '0;
            waddr_d = '0;
            state_d = MAC;
            for (int unsigned j = 0; j < NUM_PE; j++) acc_d[j] = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      MAC: begin
        if (cnt_q != '0) begin
          for (int unsigned j = 0; j < NUM_PE; j++) acc_d[j] = acc_q[j] + ACC_W'(prod[j]);
        end
        if (cnt_q == CNT_W'(NUM_INPUTS)) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q < CNT_W'(NUM_INPUTS - 1)) begin
          waddr_d = waddr_q + 32'd1;
        end
      end
      FINISH: begin
        // Lanes mapping past the last neuron in the final pass never match an index here.
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
          if (P_W'(i / NUM_PE) == p_q) out_d[i*DATA_WIDTH +: DATA_WIDTH] = res[i % NUM_PE];
        end
        for (int unsigned j = 0; j < NUM_PE; j++) acc_d[j] = '0;
        cnt_d = '0;
        if (p_q == P_W'(NUM_PASSES - 1)) begin
          state_d  = OUT;
          ovalid_d = 1'b1;
        end else begin
          p_d     = p_q + P_W'(1);
          waddr_d = waddr_q + 32'd1;
          state_d = MAC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d  = LOAD;
          ovalid_d = 1'b0;
          p_d      = '0;
          waddr_d  = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      waddr_q  <= '0;
      ovalid_q <= 1'b0;
      out_q    <= '0;
      for (int unsigned j = 0; j < NUM_PE; j++) acc_q[j] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      waddr_q  <= waddr_d;
      ovalid_q <= ovalid_d;
      out_q    <= out_d;
      acc_q    <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (vec_we) vec_q[idx_q] <= data_in;
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = ovalid_q;
  assign w_addr    = waddr_q;
  assign b_addr    = 32'(p_q);
  assign layer_out = out_q;

endmodule

// File: doc/nn_layer_tm.md
NN_LAYER_TM -- requirements
Module: nn_layer_tm

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 784, meaning input-vector length.
REQ-002 SHALL have parameter NUM_NEURONS, default 128, meaning layer output count.
REQ-003 SHALL have parameter NUM_PE, default 8, meaning parallel MAC lanes (1..NUM_NEURONS).
REQ-004 SHALL have parameter DATA_WIDTH, default 16, meaning signed two's-complement data/weight/bias width.
REQ-005 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of the fixed-point format.
REQ-006 SHALL have parameter ACT_MODE, default 1, meaning 0 = linear, 1 = ReLU.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port data_in, input, DATA_WIDTH: one input-vector element.
REQ-010 SHALL have port in_valid, input, 1 bit; in_ready, output, 1 bit: input handshake.
REQ-011 SHALL have port w_addr, output, 32 bits: weight-row address to the external weight memory.
REQ-012 SHALL have port w_data, input, NUM_PE*DATA_WIDTH: weights, lane j in bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port b_addr, output, 32 bits; b_data, input, NUM_PE*DATA_WIDTH: bias address and biases per lane.
REQ-014 SHALL have port layer_out, output, NUM_NEURONS*DATA_WIDTH: neuron i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL have port out_valid, output, 1 bit; out_ready, input, 1 bit: result handshake.

Function
REQ-016 SHALL implement states LOAD, MAC, FINISH, OUT; rst low forces LOAD.
REQ-017 In LOAD, in_ready SHALL be 1; each cycle with in_valid=1 SHALL store data_in at the next buffer index 0..NUM_INPUTS-1.
REQ-018 Acceptance of element NUM_INPUTS-1 SHALL move to MAC with pass index p=0 and wrap the buffer index to 0.
REQ-019 in_ready SHALL be 0 in MAC, FINISH and OUT; in_valid there SHALL be ignored.
REQ-020 In MAC, the block SHALL drive w_addr = p*NUM_INPUTS+k for k = 0..NUM_INPUTS-1 on consecutive cycles and b_addr = p throughout.
REQ-021 External memory read latency SHALL be exactly 1 cycle; w_data sampled at cycle c belongs to the address driven at c-1.
REQ-022 Each lane j SHALL accumulate signed(buffer[k])*signed(w_data lane j) in an accumulator of 2*DATA_WIDTH+clog2(NUM_INPUTS) bits, cleared at pass start.
REQ-023 After the last product is accumulated (NUM_INPUTS+1 cycles in MAC), the block SHALL enter FINISH for one cycle.
REQ-024 In FINISH, each lane SHALL add the sign-extended bias shifted left by FRAC_BITS, arithmetic-shift right by FRAC_BITS, and saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-025 With ACT_MODE=1, negative saturated results SHALL become 0.
REQ-026 Lane j result SHALL be written to neuron p*NUM_PE+j only if that index < NUM_NEURONS; lanes beyond it in the final partial pass SHALL be discarded.
REQ-027 Each pass SHALL take NUM_INPUTS+2 cycles; FINISH SHALL move to MAC with p+1 or, after pass ceil(NUM_NEURONS/NUM_PE)-1, to OUT.
REQ-028 In OUT, out_valid SHALL be 1 and layer_out stable until the cycle out_ready=1, then return to LOAD.
REQ-029 With out_ready held 1, out_valid SHALL rise exactly ceil(NUM_NEURONS/NUM_PE)*(NUM_INPUTS+2)+1 cycles after the last input handshake and last 1 cycle.
REQ-030 layer_out SHALL hold its value after OUT until overwritten in the next FINISH.

Reset
REQ-031 rst low SHALL asynchronously set state LOAD, buffer index 0, p 0, accumulators 0, layer_out 0, out_valid 0, w_addr 0, b_addr 0; in_ready SHALL be 1 after release.
REQ-032 rst low mid-LOAD or mid-MAC SHALL abandon the vector; no partial result SHALL be presented.

Verification (NUM_INPUTS=4, NUM_NEURONS=3, NUM_PE=2, DATA_WIDTH=16, FRAC_BITS=8 unless stated)
REQ-033 Inputs 0x0100 x4, weights 0x0080, biases 0x0040 -> all neurons 0x0240; out_valid 13 cycles after last input handshake.
REQ-034 Inputs 0x7FFF, weights 0x7FFF, bias 0x7FFF -> every neuron 0x7FFF; weights 0x8000 with ACT_MODE=0 -> 0x8000.
REQ-035 ACT_MODE=1, weights 0xFF00, inputs 0x0100 -> every neuron 0x0000; ACT_MODE=0 -> 0xFC00+bias.
REQ-036 out_ready held 0 for 10 cycles in OUT -> out_valid stays 1, layer_out unchanged, in_ready 0; release -> LOAD next cycle.
REQ-037 rst pulsed low during pass 1 -> outputs zero immediately; the next full vector yields the correct result for that vector only.
REQ-038 Lane 1 of pass 1 given weight 0x7FFF -> neuron 2 unaffected, layer_out width 48 bits, no neuron 3 written.
